// File: rtl/cache_coherence_ctrl.sv
// cache_coherence_ctrl: cache-side end of a two-cache directory coherence
// protocol. Direct-mapped cache of 1-bit blocks with INVALID/SHARED/EXCL
// lines, miss/upgrade requests to the directory and a write-back overlay
// that can interrupt either the idle or the requesting state.
module cache_coherence_ctrl #(
  parameter int ADDR_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        proc_req,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic              proc_wdata,
  output logic              proc_rdata,
  output logic              proc_done,
  output logic [1:0]        cache_req,
  output logic [ADDR_W-1:0] blk_add,
  output logic              back_data,
  input  logic              inval,
  input  logic              write_back_req,
  input  logic [ADDR_W-1:0] blocknum,
  input  logic              blk_ok,
  input  logic              blk_data,
  output logic              wb_err
);

  localparam int NUM_LINES = 2 ** IDX_W;
  localparam int TAG_W     = ADDR_W - IDX_W;

  // Cache_reqstatus encoding seen by the directory
  localparam logic [1:0] CR_IDLE = 2'd0;
  localparam logic [1:0] CR_RREQ = 2'd1;
  localparam logic [1:0] CR_EXCL = 2'd2;
  localparam logic [1:0] CR_OK   = 2'd3;

  localparam logic [1:0] PR_READ  = 2'd1;
  localparam logic [1:0] PR_WRITE = 2'd2;

  typedef enum logic [1:0] {
    LS_INVALID = 2'd0,
    LS_SHARED  = 2'd1,
    LS_EXCL    = 2'd2
  } line_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } fsm_state_t;

  fsm_state_t        state_q, state_d;
  fsm_state_t        ret_state_q, ret_state_d;
  line_state_t       lst_q [NUM_LINES];
  line_state_t       lst_d [NUM_LINES];
  logic [TAG_W-1:0]  tag_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_d [NUM_LINES];
  logic              dat_q [NUM_LINES];
  logic              dat_d [NUM_LINES];
  logic [1:0]        cache_req_q, cache_req_d;
  logic [1:0]        saved_req_q, saved_req_d;
  logic [ADDR_W-1:0] blk_add_q, blk_add_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              proc_done_q, proc_done_d;
  logic              proc_rdata_q, proc_rdata_d;
  logic              back_data_q, back_data_d;
  logic              wb_err_q, wb_err_d;

  // Index/tag views of the processor address, directory target, pending
  // request and the block currently being written back.
  logic [IDX_W-1:0] p_idx, b_idx, a_idx, w_idx;
  logic [TAG_W-1:0] p_tag, b_tag, a_tag, w_tag;
  logic             p_hit, p_excl, b_held, b_excl, w_excl;
  logic             wb_enter;
  logic             fill_now;

  assign p_idx = proc_addr[IDX_W-1:0];
  assign p_tag = proc_addr[ADDR_W-1:IDX_W];
  assign b_idx = blocknum[IDX_W-1:0];
  assign b_tag = blocknum[ADDR_W-1:IDX_W];
  assign a_idx = blk_add_q[IDX_W-1:0];
  assign a_tag = blk_add_q[ADDR_W-1:IDX_W];
  assign w_idx = wb_addr_q[IDX_W-1:0];
  assign w_tag = wb_addr_q[ADDR_W-1:IDX_W];

  assign p_hit  = (lst_q[p_idx] != LS_INVALID) && (tag_q[p_idx] == p_tag);
  assign p_excl = (lst_q[p_idx] == LS_EXCL)    && (tag_q[p_idx] == p_tag);
  assign b_held = (lst_q[b_idx] != LS_INVALID) && (tag_q[b_idx] == b_tag);
  assign b_excl = (lst_q[b_idx] == LS_EXCL)    && (tag_q[b_idx] == b_tag);
  assign w_excl = (lst_q[w_idx] == LS_EXCL)    && (tag_q[w_idx] == w_tag);

  // A fill takes precedence over a write-back request in REQ; the directory
  // never raises both in the same cycle, so this only avoids losing a fill.
  assign wb_enter = write_back_req && (cache_req_q != CR_OK) &&
                    ((state_q == S_IDLE) || ((state_q == S_REQ) && !blk_ok));

  // Next-state logic for the FSM, the line array and all registered outputs
  always_comb begin
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    lst_d        = lst_q;
    tag_d        = tag_q;
    dat_d        = dat_q;
    cache_req_d  = cache_req_q;
    saved_req_d  = saved_req_q;
    blk_add_d    = blk_add_q;
    wb_addr_d    = wb_addr_q;
    proc_done_d  = 1'b0;
    proc_rdata_d = 1'b0;
    back_data_d  = back_data_q;
    wb_err_d     = wb_err_q;
    fill_now     = 1'b0;

    if (wb_enter) begin
      // Park the current request and present the block for one cycle
      saved_req_d = cache_req_q;
      ret_state_d = state_q;
      wb_addr_d   = blocknum;
      cache_req_d = CR_OK;
      back_data_d = b_excl ? dat_q[b_idx] : 1'b0;
      if (!b_excl) wb_err_d = 1'b1;
      state_d     = S_WB;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The done pulse cycle still sees the held request; skip it
          if (!proc_done_q && (proc_req == PR_READ)) begin
            if (p_hit) begin
              proc_done_d  = 1'b1;
              proc_rdata_d = dat_q[p_idx];
            end else begin
              cache_req_d = CR_RREQ;
              blk_add_d   = proc_addr;
              state_d     = S_REQ;
            end
          end else if (!proc_done_q && (proc_req == PR_WRITE)) begin
            if (p_excl) begin
              dat_d[p_idx] = proc_wdata;
              proc_done_d  = 1'b1;
            end else begin
              cache_req_d = CR_EXCL;
              blk_add_d   = proc_addr;
              state_d     = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (blk_ok) begin
            fill_now     = 1'b1;
            tag_d[a_idx] = a_tag;
            if (cache_req_q == CR_RREQ) begin
              // A plain read clears the directory's write list entirely
              for (int i = 0; i < NUM_LINES; i++) begin
                if (lst_q[i] == LS_EXCL) lst_d[i] = LS_SHARED;
              end
              dat_d[a_idx] = blk_data;
              lst_d[a_idx] = LS_SHARED;
              proc_rdata_d = blk_data;
            end else begin
              dat_d[a_idx] = proc_wdata;
              lst_d[a_idx] = LS_EXCL;
            end
            cache_req_d = CR_IDLE;
            proc_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_WB: begin
          if (w_excl) lst_d[w_idx] = LS_SHARED;
          cache_req_d = saved_req_q;
          back_data_d = 1'b0;
          state_d     = ret_state_q;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Invalidation applies in every state; a line being filled this edge
    // is the new owner of its slot and is left alone.
    if (inval && b_held && !(fill_now && (b_idx == a_idx))) begin
      lst_d[b_idx] = LS_INVALID;
    end
  end

  // State, line array and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ret_state_q  <= S_IDLE;
      cache_req_q  <= CR_IDLE;
      saved_req_q  <= CR_IDLE;
      blk_add_q    <= '0;
      wb_addr_q    <= '0;
      proc_done_q  <= 1'b0;
      proc_rdata_q <= 1'b0;
      back_data_q  <= 1'b0;
      wb_err_q     <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        lst_q[i] <= LS_INVALID;
        tag_q[i] <= '0;
        dat_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      cache_req_q  <= cache_req_d;
      saved_req_q  <= saved_req_d;
      blk_add_q    <= blk_add_d;
      wb_addr_q    <= wb_addr_d;
      proc_done_q  <= proc_done_d;
      proc_rdata_q <= proc_rdata_d;
      back_data_q  <= back_data_d;
      wb_err_q     <= wb_err_d;
      for (int i = 0; i < NUM_LINES; i++) begin
        lst_q[i] <= lst_d[i];
        tag_q[i] <= tag_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign proc_rdata = proc_rdata_q;
  assign proc_done  = proc_done_q;
  assign cache_req  = cache_req_q;
  assign blk_add    = blk_add_q;
  assign back_data  = back_data_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_cache_coherence_ctrl.sv
// Bench for cache_coherence_ctrl: directed protocol scenarios followed by a
// randomized mix of reads, writes, write-backs and invalidations, checked
// against an address-indexed model of what the cache holds.
module tb_cache_coherence_ctrl;

  localparam int ADDR_W = 4;
  localparam int IDX_W  = 2;
  localparam int NLINES = 4;
  localparam int NADDR  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        proc_req;
  logic [ADDR_W-1:0] proc_addr;
  logic              proc_wdata;
  logic              proc_rdata;
  logic              proc_done;
  logic [1:0]        cache_req;
  logic [ADDR_W-1:0] blk_add;
  logic              back_data;
  logic              inval;
  logic              write_back_req;
  logic [ADDR_W-1:0] blocknum;
  logic              blk_ok;
  logic              blk_data;
  logic              wb_err;

  always #5 clk = ~clk;

  cache_coherence_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .proc_req       (proc_req),
    .proc_addr      (proc_addr),
    .proc_wdata     (proc_wdata),
    .proc_rdata     (proc_rdata),
    .proc_done      (proc_done),
    .cache_req      (cache_req),
    .blk_add        (blk_add),
    .back_data      (back_data),
    .inval          (inval),
    .write_back_req (write_back_req),
    .blocknum       (blocknum),
    .blk_ok         (blk_ok),
    .blk_data       (blk_data),
    .wb_err         (wb_err)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: per full address, 0 = not held, 1 = shared, 2 = exclusive.
  // Direct mapping means installing one address evicts the others that
  // share its low bits.
  int mst [NADDR];
  bit mdat [NADDR];
  bit merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void m_reset();
    for (int x = 0; x < NADDR; x++) begin
      mst[x]  = 0;
      mdat[x] = 1'b0;
    end
    merr = 1'b0;
  endfunction

  function automatic void m_install(input int a, input int st, input bit d);
    for (int x = 0; x < NADDR; x++) begin
      if ((x % NLINES) == (a % NLINES)) mst[x] = 0;
    end
    mst[a]  = st;
    mdat[a] = d;
  endfunction

  // Directory asks for block a back; prior is the request code expected
  // to reappear afterwards. Entered and left on a negedge.
  task automatic wb_inject(input int a, input int prior);
    bit held;
    bit exp_bd;
    held   = (mst[a] == 2);
    exp_bd = held ? mdat[a] : 1'b0;
    if (!held) merr = 1'b1;
    write_back_req = 1'b1;
    blocknum       = 4'(a);
    @(negedge clk);
    write_back_req = 1'b0;
    chk("wb_ok", cache_req, 3);
    chk("wb_data", back_data, exp_bd);
    chk("wb_err", wb_err, merr);
    chk("wb_nodone", proc_done, 0);
    if (held) mst[a] = 1;
    @(negedge clk);
    chk("wb_restore", cache_req, prior);
    chk("wb_bd_clear", back_data, 0);
    $display("wb    addr=%h held_excl=%0d back_data=%0d wb_err=%0d", 4'(a), held, back_data, wb_err);
  endtask

  task automatic inval_inject(input int a);
    inval    = 1'b1;
    blocknum = 4'(a);
    @(negedge clk);
    inval = 1'b0;
    mst[a] = 0;
    chk("inv_nodone", proc_done, 0);
    $display("inval addr=%h", 4'(a));
  endtask

  // One processor access. fd is the fill data the directory returns,
  // waits the extra cycles before blk_ok, wb_a / inv_a (-1 = none) are
  // directory events injected while the request is outstanding.
  task automatic do_proc(input int op, input int addr, input bit wd, input bit fd,
                         input int waits, input int wb_a, input int inv_a);
    bit hit;
    int exp_req;
    hit = (op == 1) ? (mst[addr] != 0) : (mst[addr] == 2);
    proc_req   = 2'(op);
    proc_addr  = 4'(addr);
    proc_wdata = wd;
    @(negedge clk);
    if (hit) begin
      chk("hit_done", proc_done, 1);
      chk("hit_noreq", cache_req, 0);
      if (op == 1) chk("hit_rdata", proc_rdata, mdat[addr]);
      else mdat[addr] = wd;
      proc_req = 2'd0;
      @(negedge clk);
      chk("hit_pulse", proc_done, 0);
    end else begin
      exp_req = op;
      chk("miss_req", cache_req, exp_req);
      chk("miss_addr", blk_add, addr);
      chk("miss_nodone", proc_done, 0);
      for (int k = 0; k < waits; k++) begin
        @(negedge clk);
        chk("req_hold", cache_req, exp_req);
      end
      if (wb_a >= 0) begin
        wb_inject(wb_a, exp_req);
        chk("req_addr_kept", blk_add, addr);
      end
      if (inv_a >= 0) begin
        inval_inject(inv_a);
        chk("req_after_inv", cache_req, exp_req);
      end
      blk_ok   = 1'b1;
      blk_data = fd;
      @(negedge clk);
      blk_ok   = 1'b0;
      proc_req = 2'd0;
      chk("fill_done", proc_done, 1);
      chk("fill_idle", cache_req, 0);
      if (op == 1) begin
        chk("fill_rdata", proc_rdata, fd);
        for (int x = 0; x < NADDR; x++) if (mst[x] == 2) mst[x] = 1;
        m_install(addr, 1, fd);
      end else begin
        m_install(addr, 2, wd);
      end
      @(negedge clk);
      chk("fill_pulse", proc_done, 0);
    end
    $display("proc  op=%s addr=%h hit=%0d wdata=%0d fill=%0d rdata=%0d",
             (op == 1) ? "rd" : "wr", 4'(addr), hit, wd, fd, proc_rdata);
  endtask

  initial begin
    int r, a, o, wa, ia;
    reset = 1'b1;
    proc_req = 2'd0; proc_addr = '0; proc_wdata = 1'b0;
    inval = 1'b0; write_back_req = 1'b0; blocknum = '0;
    blk_ok = 1'b0; blk_data = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_done", proc_done, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_req", cache_req, 0);
    chk("rst_addr", blk_add, 0);
    chk("rst_bd", back_data, 0);
    chk("rst_err", wb_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Cold read, upgrade, hit, write-back, invalidate
    do_proc(1, 5, 1'b0, 1'b1, 2, -1, -1);
    do_proc(2, 5, 1'b1, 1'b0, 1, -1, -1);
    do_proc(1, 5, 1'b0, 1'b0, 0, -1, -1);
    wb_inject(5, 0);
    do_proc(2, 5, 1'b1, 1'b0, 0, -1, -1);
    inval_inject(5);
    do_proc(1, 5, 1'b0, 1'b0, 1, -1, -1);
    // Write-back of EXCL line 5 while a read of 9 is pending
    do_proc(2, 5, 1'b1, 1'b0, 0, -1, -1);
    do_proc(1, 9, 1'b0, 1'b1, 1, 5, -1);
    // Invalidation of the requested block during REQ
    do_proc(1, 2, 1'b0, 1'b1, 0, -1, 2);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, NADDR - 1);
      if (r < 6) begin
        o  = $urandom_range(1, 2);
        wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NADDR - 1) : -1;
        ia = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NADDR - 1) : -1;
        do_proc(o, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), wa, ia);
      end else if (r < 8) begin
        wb_inject(a, 0);
      end else begin
        inval_inject(a);
      end
    end

    // Write-back of an unheld block sets the sticky error
    inval_inject(3);
    wb_inject(3, 0);
    do_proc(1, 3, 1'b0, 1'b1, 0, -1, -1);
    chk("err_sticky", wb_err, 1);

    // Asynchronous reset in the middle of a request
    inval_inject(6);
    proc_req  = 2'd1;
    proc_addr = 4'h6;
    @(negedge clk);
    chk("pre_rst_req", cache_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", cache_req, 0);
    chk("arst_addr", blk_add, 0);
    chk("arst_bd", back_data, 0);
    chk("arst_err", wb_err, 0);
    chk("arst_done", proc_done, 0);
    chk("arst_rdata", proc_rdata, 0);
    proc_req = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    $display("reset mid-request");
    @(negedge clk);
    do_proc(1, 5, 1'b0, 1'b1, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
